mem_responder_srm: RTL and testbench
====================================

# mem_responder_srm

Synthesisable memory responder for the device end of the core's req/gnt memory interface. It is instanced once for imem and once for dmem in the core testbench and formal harness. It accepts requests, optionally inserts pseudo-random stall cycles, services reads and byte-strobed writes from an internal word array, and flags out-of-range accesses with `mem_err`. It also checks the initiator's side of the handshake and latches a sticky violation flag when that side is broken.

## Interface
Parameters:
- `DEPTH_W`, 12: log2 of the number of 64-bit words in the array (4096 words, 32 KiB).
- `BASE_ADDR`, 64'h0: byte address of word 0. Must be 8-byte aligned.
- `STALL_MAX`, 3: maximum stall cycles inserted per transaction, range 0..15.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `g_resetn` in 1: synchronous, active-low reset.
- `mem_req` in 1: request valid.
- `mem_addr` in 64: request byte address.
- `mem_wen` in 1: 1 = write, 0 = read.
- `mem_strb` in 8: write byte strobes; bit i enables byte lane i.
- `mem_wdata` in 64: write data.
- `mem_gnt` out 1: response valid; the transaction completes in this cycle.
- `mem_err` out 1: response error; valid only while `mem_gnt`=1.
- `mem_rdata` out 64: read data; valid only while `mem_gnt`=1.
- `stall_en` in 1: 1 = enable random stalls, 0 = zero stalls.
- `proto_viol` out 1: sticky handshake-violation flag.

## Operation
- Address decode:
  - `off = mem_addr - BASE_ADDR` (64-bit, wraps modulo 2^64).
  - In range iff `off < 8*2^DEPTH_W`. Word index is `off[DEPTH_W+2:3]`. `off[2:0]` is ignored.
- State machine: IDLE, WAIT, RESP.
  - IDLE, `mem_req`=1:
    - Capture addr, wen, strb and wdata.
    - Load the stall counter with `stall_en ? min(lfsr[3:0], STALL_MAX) : 0`.
    - Go to WAIT if the loaded value is non-zero, else go to RESP.
  - WAIT:
    - Decrement the counter each cycle. Go to RESP on the cycle the counter reaches 1.
    - If `mem_req`=0, go to IDLE with no response and no write.
    - If any request field differs from the captured value, set `proto_viol`. The transaction still completes using the captured values.
  - RESP:
    - `mem_gnt`=1 for exactly one cycle. The state always returns to IDLE next.
    - The request fields are checked in this cycle the same way as in WAIT.
- Read, in range: `mem_rdata` = array[word]; `mem_err`=0.
- Write, in range: at the edge that enters RESP, each byte lane with `strb[i]`=1 is updated. During `mem_gnt`, `mem_rdata`=0 and `mem_err`=0.
- Out of range, read or write: `mem_err`=1 and `mem_rdata`=0. The array is not modified.
- Write with `strb`=0: completes normally with no array change.
- Read data is always registered; there is no combinational path from `mem_addr` to `mem_rdata`.
- A read granted after a write to the same word returns the written data. No bypass path is needed because the write commits before any later RESP.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of state.
- `proto_viol`: once set, it stays at 1 until reset.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_gnt`=0, `mem_err`=0, `mem_rdata`=0, `proto_viol`=0.
  - LFSR = `LFSR_SEED`, stall counter = 0.
  - Array contents are not reset.
- Latency: request first seen high in cycle N → `mem_gnt` in cycle N+1+s, where s is the loaded stall count (0..`STALL_MAX`).
- Back-to-back: after RESP the state is always IDLE. If `mem_req` is still high in the cycle after `mem_gnt`, it is a new request. Peak throughput is one transaction per 2 cycles.
- The cycle in which `mem_gnt`=1 is the handshake completion. The initiator may change or drop `mem_req` in the following cycle.
- Reset mid-operation (`g_resetn`=0 in WAIT or RESP):
  - Next state is IDLE and `mem_gnt` is 0 in the next cycle.
  - A write captured but not yet committed is dropped.
  - A write already committed on entry to RESP is retained.
- `stall_en` is sampled only when a request is captured in IDLE. Changing it mid-transaction has no effect.

## Test plan
- Reset, then write addr `BASE_ADDR+0x10`, strb 0xFF, wdata 0x0123456789ABCDEF, with `stall_en`=0. Then read the same address. Expect: `mem_gnt` at N+1 for both transactions, `mem_err`=0, rdata 0x0123456789ABCDEF.
- Partial write to the same word with strb 0x0F, wdata 0xFFFFFFFF_00000000, then read. Expect rdata 0x01234567_00000000.
- Read at `BASE_ADDR + 0x8000` with `DEPTH_W`=12. Expect `mem_gnt`=1, `mem_err`=1, rdata 0. A later read of word 0 shows no corruption.
- `stall_en`=1, `STALL_MAX`=3, 100 random reads. Expect:
  - every grant latency in 1..4 cycles;
  - at least one latency of 1 and at least one of 4;
  - exactly one `mem_gnt` per request.
- Change `mem_addr` during WAIT. Expect `proto_viol` rises the next cycle, the response uses the captured address, and the flag stays 1 until `g_resetn`=0.
- Hold `mem_req` high continuously with `stall_en`=0. Expect `mem_gnt` on alternate cycles. Assert `g_resetn`=0 during RESP: `mem_gnt`=0 in the next cycle and `proto_viol`=0.

Source files
------------

// File: rtl/mem_responder_srm.sv
// Device-side responder for the req/gnt memory interface: word array with byte-strobed
// writes, optional LFSR-driven stall insertion, range checking and a sticky handshake monitor.
module mem_responder_srm #(
  parameter int          DEPTH_W   = 12,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          STALL_MAX = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata,
  input  logic        stall_en,
  output logic        proto_viol
);

  localparam logic [63:0] SPAN      = 64'd8 << DEPTH_W;
  localparam logic [3:0]  STALL_CAP = 4'(STALL_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, stall_ld;
  logic [15:0] lfsr;
  logic        lfsr_fb;

  logic [63:0] cap_addr, cap_wdata;
  logic        cap_wen;
  logic [7:0]  cap_strb;

  logic [63:0] eff_addr, eff_wdata;
  logic        eff_wen;
  logic [7:0]  eff_strb;

  logic [63:0]        off;
  logic               in_range;
  logic [DEPTH_W-1:0] widx;
  logic               enter_resp, commit_wr, mismatch;

  logic [63:0] rdata_q;
  logic        err_q, viol_q;

  logic [63:0] mem [0:(1<<DEPTH_W)-1];

  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign stall_ld = stall_en ? ((lfsr[3:0] > STALL_CAP) ? STALL_CAP : lfsr[3:0]) : 4'd0;

  // A zero-stall request enters RESP straight from IDLE, so decode the live inputs then.
  assign eff_addr  = (state == IDLE) ? mem_addr  : cap_addr;
  assign eff_wen   = (state == IDLE) ? mem_wen   : cap_wen;
  assign eff_strb  = (state == IDLE) ? mem_strb  : cap_strb;
  assign eff_wdata = (state == IDLE) ? mem_wdata : cap_wdata;

  assign off      = eff_addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign widx     = off[DEPTH_W+2:3];

  assign mismatch = mem_req && ((mem_addr != cap_addr) || (mem_wen != cap_wen) ||
                                (mem_strb != cap_strb) || (mem_wdata != cap_wdata));

  assign commit_wr = enter_resp && eff_wen && in_range && g_resetn;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (stall_ld != 4'd0) begin
            state_nxt = WAIT;
            cnt_nxt   = stall_ld;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
            cnt_nxt    = 4'd0;
          end
        end
      end
      WAIT: begin
        if (!mem_req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!g_resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lfsr    <= LFSR_SEED;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      err_q   <= enter_resp && !in_range;
      rdata_q <= (enter_resp && !eff_wen && in_range) ? mem[widx] : 64'd0;
      viol_q  <= viol_q || (((state == WAIT) || (state == RESP)) && mismatch);
    end
  end

  // Request fields are plain data and need no reset.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && mem_req) begin
      cap_addr  <= mem_addr;
      cap_wen   <= mem_wen;
      cap_strb  <= mem_strb;
      cap_wdata <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (commit_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (eff_strb[i]) mem[widx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

  assign mem_gnt    = (state == RESP);
  assign mem_err    = err_q;
  assign mem_rdata  = rdata_q;
  assign proto_viol = viol_q;

endmodule

// File: tb/tb_mem_responder_srm.sv
// Scoreboard bench for mem_responder_srm: the driver pushes expected responses from a
// word-level memory model, and a monitor pops and compares them on every grant.
module tb_mem_responder_srm;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        g_resetn;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic        stall_en;
  logic        proto_viol;

  mem_responder_srm #(
    .DEPTH_W   (12),
    .BASE_ADDR (BASE),
    .STALL_MAX (3),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clock      (clock),
    .g_resetn   (g_resetn),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_err    (mem_err),
    .mem_rdata  (mem_rdata),
    .stall_en   (stall_en),
    .proto_viol (proto_viol)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [63:0] mdl [longint];
  logic [63:0] pool [16];
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  logic        seen1 = 1'b0;
  logic        seen4 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic in_rng(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return o < 64'h8000;
  endfunction

  function automatic longint widx(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return longint'(o >> 3);
  endfunction

  // Reference behaviour: compute the response and apply the write to the model.
  task automatic push_exp(input logic [63:0] a, input logic w, input logic [7:0] s,
                          input logic [63:0] d);
    exp_t        e;
    logic [63:0] old;
    e.err   = 1'b0;
    e.rdata = 64'd0;
    if (!in_rng(a)) begin
      e.err = 1'b1;
    end else if (w) begin
      old = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0;
      for (int i = 0; i < 8; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      mdl[widx(a)] = old;
    end else begin
      e.rdata = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0;
    end
    expq.push_back(e);
  endtask

  task automatic txn(input logic [63:0] a, input logic w, input logic [7:0] s,
                     input logic [63:0] d, input logic se, output int l);
    push_exp(a, w, s, d);
    @(posedge clock); #1;
    mem_addr  = a;
    mem_wen   = w;
    mem_strb  = s;
    mem_wdata = d;
    stall_en  = se;
    mem_req   = 1'b1;
    l = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_gnt) begin
        l = k;
        break;
      end
    end
    @(posedge clock); #1;
    mem_req  = 1'b0;
    stall_en = $urandom_range(0, 1);
    if (l < 0) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      void'(expq.pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (mem_gnt) begin
      if (expq.size() == 0) begin
        chk("unexpected_gnt", 64'd1, 64'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("rsp_err", 64'(mem_err), 64'(mon_e.err));
        chk("rsp_rdata", mem_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    int          gk;
    g_resetn  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 64'd0;
    mem_wen   = 1'b0;
    mem_strb  = 8'd0;
    mem_wdata = 64'd0;
    stall_en  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt", 64'(mem_gnt), 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    chk("rst_viol", 64'(proto_viol), 64'd0);
    @(posedge clock); #1;
    g_resetn = 1'b1;

    // Directed: full write, read back, partial write, strobe-less write.
    txn(BASE + 64'h0, 1'b1, 8'hFF, 64'hA5A5_0000_1111_2222, 1'b0, lat);
    chk("lat_w0", 64'(lat), 64'd1);
    txn(BASE + 64'h10, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, lat);
    chk("lat_w", 64'(lat), 64'd1);
    txn(BASE + 64'h10, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    chk("lat_r", 64'(lat), 64'd1);
    txn(BASE + 64'h10, 1'b1, 8'h0F, 64'hFFFF_FFFF_0000_0000, 1'b0, lat);
    txn(BASE + 64'h15, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    chk("partial_model", mdl[2], 64'h0123_4567_0000_0000);
    txn(BASE + 64'h10, 1'b1, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, lat);
    txn(BASE + 64'h10, 1'b0, 8'h00, 64'd0, 1'b0, lat);

    // Out of range: one past the end, aliasing write, below base; then no corruption.
    txn(BASE + 64'h8000, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    txn(BASE + 64'h8010, 1'b1, 8'hFF, 64'h5555_5555_5555_5555, 1'b0, lat);
    txn(BASE - 64'h8, 1'b1, 8'hFF, 64'h6666_6666_6666_6666, 1'b0, lat);
    txn(BASE + 64'h0, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    txn(BASE + 64'h10, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    txn(BASE + 64'h7FF8, 1'b1, 8'hFF, 64'h7777_8888_9999_AAAA, 1'b1, lat);
    txn(BASE + 64'h7FF8, 1'b0, 8'h00, 64'd0, 1'b1, lat);

    // Fill a pool of words, then random stalled reads with latency bookkeeping.
    for (int i = 0; i < 16; i++) begin
      pool[i] = BASE + {49'd0, 12'($urandom_range(3, 4094)), 3'd0};
      txn(pool[i], 1'b1, 8'hFF, {$urandom, $urandom}, 1'($urandom_range(0, 1)), lat);
    end
    for (int i = 0; i < 1000; i++) begin
      if (i >= 100 && seen1 && seen4) break;
      repeat ($urandom_range(0, 2)) @(posedge clock);
      if ($urandom_range(0, 9) == 0) a = BASE + 64'h8000 + 64'($urandom_range(0, 65535));
      else a = pool[$urandom_range(0, 15)] + 64'($urandom_range(0, 7));
      txn(a, 1'b0, 8'h00, 64'd0, 1'b1, lat);
      chk("lat_range", 64'(lat >= 1 && lat <= 4), 64'd1);
      if (lat == 1) seen1 = 1'b1;
      if (lat == 4) seen4 = 1'b1;
    end
    chk("lat1_seen", 64'(seen1), 64'd1);
    chk("lat4_seen", 64'(seen4), 64'd1);

    // Address changes while the request is pending: sticky flag, captured address used.
    chk("viol_pre", 64'(proto_viol), 64'd0);
    a = pool[3];
    b = pool[7] ^ 64'h8;
    push_exp(a, 1'b0, 8'h00, 64'd0);
    @(posedge clock); #1;
    mem_addr = a; mem_wen = 1'b0; mem_strb = 8'h00; mem_wdata = 64'd0;
    stall_en = 1'b1; mem_req = 1'b1;
    @(negedge clock);
    chk("viol_gnt_k0", 64'(mem_gnt), 64'd0);
    @(posedge clock); #1;
    mem_addr = b;
    gk = -1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      if (k == 2) chk("viol_rise", 64'(proto_viol), 64'd1);
      if (mem_gnt && gk < 0) gk = k;
      if (gk > 0 && k >= 2) break;
      @(posedge clock); #1;
      if (gk > 0) mem_req = 1'b0;
    end
    @(posedge clock); #1;
    mem_req = 1'b0;
    chk("viol_lat", 64'(gk >= 1 && gk <= 4), 64'd1);
    txn(pool[5], 1'b0, 8'h00, 64'd0, 1'b1, lat);
    chk("viol_hold", 64'(proto_viol), 64'd1);

    // Continuous request: grant every other cycle; reset during RESP clears everything.
    for (int i = 0; i < 3; i++) push_exp(BASE + 64'h10, 1'b0, 8'h00, 64'd0);
    @(posedge clock); #1;
    mem_addr = BASE + 64'h10; mem_wen = 1'b0; mem_strb = 8'h00; mem_wdata = 64'd0;
    stall_en = 1'b0; mem_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("alt_gnt", 64'(mem_gnt), 64'(k % 2 == 1));
      chk("viol_sticky", 64'(proto_viol), 64'd1);
    end
    g_resetn = 1'b0;
    @(negedge clock);
    chk("rst_resp_gnt", 64'(mem_gnt), 64'd0);
    chk("rst_resp_viol", 64'(proto_viol), 64'd0);
    chk("rst_resp_rdata", mem_rdata, 64'd0);
    mem_req = 1'b0;
    @(posedge clock); #1;
    g_resetn = 1'b1;

    // Array contents survive reset.
    txn(BASE + 64'h10, 1'b0, 8'h00, 64'd0, 1'b0, lat);
    txn(pool[0], 1'b0, 8'h00, 64'd0, 1'b1, lat);
    repeat (3) @(posedge clock);
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
